// File: rtl/nios2_oci_dct_pkg.sv
// rtl/nios2_oci_dct_pkg.sv - shared state encoding and default geometry for the DCT trace collector
package nios2_oci_dct_pkg;

  localparam int DCT_SLOT_W = 10;
  localparam int DCT_SLOTS  = 3;
  localparam int DCT_CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_CAPTURE = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_DONE    = 2'd2
  } dct_state_e;

endpackage

// File: rtl/nios2_oci_dct_slot_fifo.sv
// rtl/nios2_oci_dct_slot_fifo.sv - show-ahead slot FIFO, up to SLOTS writes and one read per cycle
module nios2_oci_dct_slot_fifo #(
  parameter int SLOT_W = 10,
  parameter int SLOTS  = 3,
  parameter int DEPTH  = 16,
  parameter int CW     = $clog2(SLOTS + 1),
  parameter int LVL_W  = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [CW-1:0]            wr_cnt,
  input  logic [SLOT_W*SLOTS-1:0]  wr_data,
  input  logic                     rd_en,
  output logic [SLOT_W-1:0]        rd_data,
  output logic [LVL_W-1:0]         level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [SLOT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  // Slots 0..wr_cnt-1 land at consecutive addresses starting at wr_ptr; pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!reset && !flush) begin
      for (int i = 0; i < SLOTS; i++) begin
        if (i < int'(wr_cnt)) begin
          mem[wr_ptr + PTR_W'(i)] <= wr_data[i*SLOT_W +: SLOT_W];
        end
      end
    end
  end

  // Pointer and occupancy bookkeeping; flush empties the FIFO without touching storage.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(wr_cnt);
      if (rd_en) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      level <= level + LVL_W'(wr_cnt) - LVL_W'(rd_en);
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/nios2_oci_dct_trace_collector.sv
// rtl/nios2_oci_dct_trace_collector.sv - unpacks DCT frames into a slot FIFO and streams them out
module nios2_oci_dct_trace_collector
  import nios2_oci_dct_pkg::*;
#(
  parameter int SLOT_W = DCT_SLOT_W,
  parameter int SLOTS  = DCT_SLOTS,
  parameter int CNT_W  = DCT_CNT_W,
  parameter int DEPTH  = 16,
  parameter int STAT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [SLOT_W*SLOTS-1:0]  dct_buffer,
  input  logic [CNT_W-1:0]         dct_count,
  input  logic                     dct_valid,
  input  logic                     test_ending,
  input  logic                     test_has_ended,
  output logic [SLOT_W-1:0]        trace_data,
  output logic                     trace_valid,
  input  logic                     trace_ready,
  output logic [STAT_W-1:0]        frames_captured,
  output logic [STAT_W-1:0]        slots_dropped,
  output logic                     overflow,
  output logic                     count_err,
  output logic                     drain_done
);

  localparam int CW    = $clog2(SLOTS + 1);
  localparam int LVL_W = $clog2(DEPTH + 1);

  dct_state_e        state;
  dct_state_e        state_nxt;
  logic              cnt_over;
  logic [CW-1:0]     eff_cnt;
  logic [LVL_W-1:0]  level;
  logic [LVL_W-1:0]  free;
  logic              sample;
  logic              accept;
  logic              reject;
  logic [CW-1:0]     push_cnt;
  logic              pop;
  logic              flush;
  logic [SLOT_W-1:0] rd_data;
  logic [STAT_W:0]   drop_sum;

  // Clamp the advertised slot count to what the frame can physically carry.
  assign cnt_over = dct_count > CNT_W'(SLOTS);
  assign eff_cnt  = cnt_over ? CW'(SLOTS) : CW'(dct_count);

  // Accept whole frames only; a pop in the same cycle is not counted as free space.
  assign free     = LVL_W'(DEPTH) - level;
  assign sample   = (state == ST_CAPTURE) && dct_valid && !test_has_ended && (eff_cnt != '0);
  assign accept   = sample && (free >= LVL_W'(eff_cnt));
  assign reject   = sample && !accept;
  assign push_cnt = accept ? eff_cnt : '0;

  assign trace_valid = (level != '0) && (state != ST_DONE);
  assign pop         = trace_valid && trace_ready;
  assign trace_data  = trace_valid ? rd_data : '0;
  assign flush       = test_has_ended && (state != ST_DONE);
  assign drain_done  = (state == ST_DONE);

  assign drop_sum = {1'b0, slots_dropped} + {{(STAT_W + 1 - CW){1'b0}}, eff_cnt};

  nios2_oci_dct_slot_fifo #(
    .SLOT_W (SLOT_W),
    .SLOTS  (SLOTS),
    .DEPTH  (DEPTH),
    .CW     (CW),
    .LVL_W  (LVL_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .wr_cnt  (push_cnt),
    .wr_data (dct_buffer),
    .rd_en   (pop),
    .rd_data (rd_data),
    .level   (level)
  );

  // Next state: abort wins over ending; DRAIN finishes once the last slot leaves.
  always_comb begin
    state_nxt = state;
    if (test_has_ended) begin
      state_nxt = ST_DONE;
    end else begin
      case (state)
        ST_CAPTURE: if (test_ending) state_nxt = ST_DRAIN;
        ST_DRAIN:   if ((level == '0) || ((level == LVL_W'(1)) && pop)) state_nxt = ST_DONE;
        default:    state_nxt = ST_DONE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_CAPTURE;
    end else begin
      state <= state_nxt;
    end
  end

  // Saturating statistics and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      frames_captured <= '0;
      slots_dropped   <= '0;
      overflow        <= 1'b0;
      count_err       <= 1'b0;
    end else begin
      if (accept && (frames_captured != '1)) begin
        frames_captured <= frames_captured + STAT_W'(1);
      end
      if (reject) begin
        slots_dropped <= drop_sum[STAT_W] ? '1 : drop_sum[STAT_W-1:0];
        overflow      <= 1'b1;
      end
      if ((state == ST_CAPTURE) && dct_valid && !test_has_ended && cnt_over) begin
        count_err <= 1'b1;
      end
    end
  end

endmodule
